// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Multi-channel debouncer for front-panel switches and buttons. Each channel
// brings its raw switch into the clock domain through a two-flop synchroniser.
// A change is accepted only after the synchronised value has differed from the
// current level for STABLE_CYCLES consecutive cycles. The channel then emits a
// clean level, one-cycle press/release pulses, and an auto-repeat pulse train
// while the button is held.
//
// Ports
//   clk           in   1         single clock for all logic
//   rst           in   1         asynchronous, active-high reset
//   switch        in   CHANNELS  raw asynchronous switch inputs, active-high
//   level         out  CHANNELS  debounced level
//   rise          out  CHANNELS  one-cycle pulse on level 0->1 (press)
//   fall          out  CHANNELS  one-cycle pulse on level 1->0 (release)
//   repeat_pulse  out  CHANNELS  one-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] switch,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int CW   = $clog2(STABLE_CYCLES);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]    r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_level;
        logic          r_rise;
        logic          r_fall;
        logic          r_rep;
        state_t        r_state;
        logic [HW-1:0] r_hcnt;

        logic          w_s;
        logic          w_accept;
        logic          w_rise_nxt;
        logic          w_fall_nxt;
        state_t        w_state_nxt;
        logic [HW-1:0] w_hcnt_nxt;
        logic          w_rep_nxt;

        assign w_s        = r_sync[1];
        assign w_accept   = (w_s != r_level) && (r_cnt == STABLE_LAST);
        assign w_rise_nxt = w_accept && w_s;
        assign w_fall_nxt = w_accept && !w_s;

        // Synchroniser, stability qualification and edge pulses. Any cycle in
        // which the synchronised value matches the level clears the counter,
        // so a single-cycle bounce restarts qualification from zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync  <= '0;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], switch[g]};
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt   <= '0;
                    r_level <= w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Hold FSM state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_rep   <= w_rep_nxt;
            end
        end

        // Hold FSM next state. The decision uses the same-edge rise/fall
        // terms, so entry to HOLD coincides with the rise pulse and a release
        // pre-empts a repeat pulse that would land in the fall cycle.
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_rep_nxt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise_nxt) begin
                        w_state_nxt = ST_HOLD;
                        w_hcnt_nxt  = '0;
                    end
                end
                ST_HOLD: begin
                    if (w_fall_nxt) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == HOLD_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_hcnt_nxt  = '0;
                        w_rep_nxt   = 1'b1;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (w_fall_nxt) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == REPEAT_LAST) begin
                        w_hcnt_nxt = '0;
                        w_rep_nxt  = 1'b1;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        assign level[g]        = r_level;
        assign rise[g]         = r_rise;
        assign fall[g]         = r_fall;
        assign repeat_pulse[g] = r_rep;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Parametrised multi-channel debouncer for the front-panel switches and buttons of the clock design. Each channel synchronises a raw asynchronous switch, qualifies it by requiring a stable level for a programmable number of cycles, and produces a clean level plus one-cycle press and release pulses. It also produces an auto-repeat pulse train while a button is held, so time-set logic can step faster on a long press. It sits between the board pins and the time-keeping and speed-control logic.

## Interface
- `CHANNELS`, 4: number of independent switch channels, at least 1.
- `STABLE_CYCLES`, 16: consecutive synchronised cycles at the new level needed to accept a change, at least 2.
- `HOLD_CYCLES`, 64: cycles from a press to the first repeat pulse, at least 2.
- `REPEAT_CYCLES`, 16: cycles between subsequent repeat pulses, at least 2.
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: asynchronous, active-high reset.
- `switch`  in  CHANNELS: raw switch inputs, asynchronous to `clk`, active-high.
- `level`  out  CHANNELS: debounced switch level.
- `rise`  out  CHANNELS: one-cycle pulse when `level` goes 0→1 (press).
- `fall`  out  CHANNELS: one-cycle pulse when `level` goes 1→0 (release).
- `repeat_pulse`  out  CHANNELS: one-cycle auto-repeat pulse while held.

## Operation
- All outputs are registered. Channels are fully independent with no shared state.
- Reset: the synchroniser flops, `level`, `rise`, `fall`, `repeat_pulse`, all counters and all FSMs clear to 0/IDLE immediately while `rst` is high.
- Synchroniser: two flops per channel; `s` is the second flop output.
- Stability counter `cnt`, width `$clog2(STABLE_CYCLES)`:
  - When `s == level`, `cnt` ← 0.
  - When `s != level` and `cnt == STABLE_CYCLES-1`, the channel accepts the change: `level` ← `s`, `cnt` ← 0, and `rise` or `fall` is 1 for that cycle only.
  - Otherwise `cnt` increments.
  - Any single-cycle return of `s` to `level` (a bounce) restarts qualification.
- Hold FSM, one per channel, with states IDLE, HOLD and REPEAT. Hold counter `hcnt` has width `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES))`.
  - IDLE→HOLD on the cycle `rise` is asserted, with `hcnt` ← 0.
  - In HOLD: `hcnt` increments. At `hcnt == HOLD_CYCLES-1`, `repeat_pulse` fires, `hcnt` ← 0 and the FSM moves to REPEAT.
  - In REPEAT: `hcnt` increments. At `hcnt == REPEAT_CYCLES-1`, `repeat_pulse` fires and `hcnt` ← 0.
  - HOLD or REPEAT → IDLE on the cycle `fall` is asserted, with `hcnt` ← 0.
  - `fall` has priority: no `repeat_pulse` is issued in the same cycle as `fall`.
- `rise` and `fall` are never both 1 on a channel. `repeat_pulse` is never 1 in the `rise` cycle.
- After reset, a switch already held high is treated as a fresh press: it qualifies normally and issues `rise`.

## Timing
- Let the new switch value first be sampled at edge k. Then `s` changes after edge k+1, and `level` and `rise`/`fall` update at edge k+1+`STABLE_CYCLES`.
- Press-to-`level` latency is therefore `STABLE_CYCLES`+1 clocks, assuming no bounce.
- A pulse at the input shorter than `STABLE_CYCLES` synchronised cycles produces no output activity.
- If `rise` is asserted in cycle t, `repeat_pulse` is asserted in cycles t+`HOLD_CYCLES`, t+`HOLD_CYCLES`+`REPEAT_CYCLES`, t+`HOLD_CYCLES`+2·`REPEAT_CYCLES`, and so on, until `fall`.
- Release qualification also takes `STABLE_CYCLES`+1 clocks. Repeat pulses continue during that window until the `fall` cycle.
- Reset assertion mid-operation clears outputs asynchronously, without waiting for a clock. Release of reset takes effect at the first `clk` edge after deassertion.

## Test plan
All scenarios use `CHANNELS`=2, `STABLE_CYCLES`=4, `HOLD_CYCLES`=8, `REPEAT_CYCLES`=3.

- **Clean press and release:** assert `rst` with `switch`=2'b11, then release `rst` and hold `switch`=0. Drive `switch[0]` 0→1, first sampled at edge 10 → `level[0]`=1 and `rise[0]`=1 after edge 15, with `rise[0]` high for exactly one cycle. While `rst` is high, all outputs read 0.
- **Bounce:** `switch[0]` goes high 3 cycles, low 1 cycle, then high steadily, with the final rising sample at edge 20 → no `rise` before edge 25, and `rise[0]` exactly at edge 25.
- **Glitch rejection:** a 3-cycle high pulse on `switch[1]` → `level[1]`, `rise[1]`, `fall[1]` and `repeat_pulse[1]` all stay 0 throughout.
- **Hold and auto-repeat:** `rise[1]` at cycle t and `switch[1]` held high → `repeat_pulse[1]` at t+8, t+11, t+14, t+17. On release, `fall[1]` fires one cycle, with no `repeat_pulse[1]` in that cycle or after it.
- **Simultaneous channels:** both switches rise on the same edge → `rise`=2'b11 in the same cycle. Then `switch[0]` releases mid-repeat → `repeat_pulse[1]` keeps its 3-cycle cadence, unaffected.
- **Reset mid-repeat:** assert `rst` while channel 1 is in REPEAT → `level`, `repeat_pulse` and all pulses go to 0 without waiting for a clock. Release `rst` with `switch[1]` still high → `rise[1]` 5 edges later, followed by the first `repeat_pulse[1]` 8 cycles after that `rise[1]`.
